// File: rtl/keypad_scan_4x4_pkg.sv
// Shared constants, the key map and the frame-result type for the keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Frame classification: nothing pressed, exactly one key, or an ambiguous chord.
  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } frame_res_e;

  // Hex code for each intersection, index = row*4 + col.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Number of set bits in a frame snapshot.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port connection.
interface keypad_scan_4x4_if;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_o;
  logic       valid_o;
  logic       pressed_o;

  // Consumer / keypad side: drives the columns, observes rows and key events.
  modport master (
    output col_i,
    input  row_o,
    input  key_o,
    input  valid_o,
    input  pressed_o
  );

  // Scanner side.
  modport slave (
    input  col_i,
    output row_o,
    output key_o,
    output valid_o,
    output pressed_o
  );
endinterface

// File: rtl/keypad_scan_4x4_row_scanner.sv
// Row scanner: holds each row active for SCAN_COUNT cycles, latches the synchronized
// columns on the last tick of the row and presents a full 16-bit snapshot per frame.
module kp_row_scanner #(
  parameter int SCAN_COUNT = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  col_n_s_i,     // synchronized columns, active-low
  output logic [3:0]  row_o,         // active-low one-hot row drive
  output logic [15:0] frame_o,       // bit row*4+col set = intersection pressed
  output logic        frame_done_o   // one-cycle pulse, frame_o valid
);

  localparam int TICK_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_COUNT - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        row_q, row_d;
  logic [15:0]       snap_q, snap_d;
  logic [15:0]       frame_q, frame_d;
  logic              done_q, done_d;

  // Tick/row sequencing and column capture on the last tick of each row.
  always_comb begin
    tick_d  = tick_q + TICK_W'(1);
    row_d   = row_q;
    snap_d  = snap_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      row_d  = row_q + 2'd1;
      snap_d[{row_q, 2'b00} +: 4] = ~col_n_s_i;
      if (row_q == 2'd3) begin
        frame_d = {~col_n_s_i, snap_q[11:0]};
        done_d  = 1'b1;
      end
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q  <= '0;
      row_q   <= 2'd0;
      snap_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign row_o        = ~(4'b0001 << row_q);
  assign frame_o      = frame_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: synchronizes the columns, classifies each scan frame,
// debounces over DEB_SCANS identical frames and emits one strobe per accepted key.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT = 50000,
  parameter int DEB_SCANS  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  keypad_scan_4x4_if.slave kp
);

  localparam int STAB_W = $clog2(DEB_SCANS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEB_SCANS);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  // Column synchronizer, idle = all high (no key).
  logic [3:0] col_s1_q, col_s1_d;
  logic [3:0] col_s2_q, col_s2_d;

  // Debounce and output state.
  frame_res_e        prev_res_q, prev_res_d;
  logic [3:0]        prev_code_q, prev_code_d;
  logic              hist_q, hist_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [3:0]        key_q, key_d;
  logic              pressed_q, pressed_d;
  logic              valid_q, valid_d;

  logic [15:0] frame_w;
  logic        frame_done_w;
  logic [3:0]  row_w;

  kp_row_scanner #(
    .SCAN_COUNT (SCAN_COUNT)
  ) u_scan (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .col_n_s_i    (col_s2_q),
    .row_o        (row_w),
    .frame_o      (frame_w),
    .frame_done_o (frame_done_w)
  );

  // Synchronizer next-state.
  always_comb begin
    col_s1_d = kp.col_i;
    col_s2_d = col_s1_q;
  end

  // Frame classification: count pressed intersections and locate the single hit.
  frame_res_e res_w;
  logic [3:0] hit_idx_w;
  logic [3:0] res_code_w;
  logic [4:0] hit_cnt_w;

  always_comb begin
    hit_idx_w = 4'd0;
    hit_cnt_w = popcount16(frame_w);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (frame_w[r*COLS + c]) begin
          hit_idx_w = 4'(r*COLS + c);
        end
      end
    end
    res_code_w = KEYMAP[hit_idx_w];
    if (hit_cnt_w == 5'd0) begin
      res_w = RES_NONE;
    end else if (hit_cnt_w == 5'd1) begin
      res_w = RES_KEY;
    end else begin
      res_w = RES_MULTI;
    end
  end

  // Per-frame debounce: count identical consecutive results and act at DEB_SCANS.
  logic              same_w;
  logic [STAB_W-1:0] stab_next_w;

  always_comb begin
    prev_res_d  = prev_res_q;
    prev_code_d = prev_code_q;
    hist_d      = hist_q;
    stab_d      = stab_q;
    key_d       = key_q;
    pressed_d   = pressed_q;
    valid_d     = 1'b0;
    same_w      = hist_q && (prev_res_q == res_w) &&
                  ((res_w == RES_NONE) || (prev_code_q == res_code_w));
    stab_next_w = same_w ? ((stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE) : STAB_ONE;
    if (frame_done_w) begin
      hist_d     = 1'b1;
      prev_res_d = res_w;
      if (res_w == RES_MULTI) begin
        // A chord never changes the accepted state; it only restarts the count.
        stab_d = '0;
      end else begin
        stab_d      = stab_next_w;
        prev_code_d = res_code_w;
        if (stab_next_w == STAB_MAX) begin
          if ((res_w == RES_KEY) && (!pressed_q || (key_q != res_code_w))) begin
            key_d     = res_code_w;
            pressed_d = 1'b1;
            valid_d   = 1'b1;
          end else if (res_w == RES_NONE) begin
            pressed_d = 1'b0;
          end
        end
      end
    end
  end

  // State registers; reset aborts any frame and forgets history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      prev_res_q  <= RES_NONE;
      prev_code_q <= 4'd0;
      hist_q      <= 1'b0;
      stab_q      <= '0;
      key_q       <= 4'd0;
      pressed_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      prev_res_q  <= prev_res_d;
      prev_code_q <= prev_code_d;
      hist_q      <= hist_d;
      stab_q      <= stab_d;
      key_q       <= key_d;
      pressed_q   <= pressed_d;
      valid_q     <= valid_d;
    end
  end

  assign kp.row_o     = row_w;
  assign kp.key_o     = key_q;
  assign kp.valid_o   = valid_q;
  assign kp.pressed_o = pressed_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: keypad model, frame-level reference model with a strobe
// scoreboard, directed scenarios and a randomized key sequence.
module tb_keypad_scan_4x4;

  localparam int SC  = 4;
  localparam int DEB = 2;
  localparam int FRAME = 4 * SC;
  localparam bit [3:0] TB_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_4x4_if kp_if ();

  keypad_scan_4x4 #(
    .SCAN_COUNT (SC),
    .DEB_SCANS  (DEB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .kp    (kp_if)
  );

  // Keypad: bit r*4+c of mask = key at (row r, col c) is held down.
  logic [15:0] mask = 16'd0;
  logic [3:0]  col_w;
  always_comb begin
    col_w = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_if.row_o[r] && mask[r*4+c]) col_w[c] = 1'b0;
  end
  assign kp_if.col_i = col_w;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int last_valid_k = 0;

  // Reference model state.
  int unsigned k;
  logic [15:0] p1, p2, samp;
  int          hits, kind, prev_kind, stab;
  logic [3:0]  hit_code, prev_code, exp_key;
  logic        exp_pressed;
  bit          cmp_due;
  logic [3:0]  exp_q [$];

  // Model: the row sampled at cycle k sees the keypad two cycles earlier (synchronizer);
  // at each frame end classify and debounce per the key-acceptance rules.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = 0; p1 = '0; p2 = '0; hits = 0; stab = 0; prev_kind = -1;
        hit_code = '0; prev_code = '0; exp_key = '0; exp_pressed = 1'b0;
        cmp_due = 1'b0; exp_q.delete();
      end else begin
        k++;
        samp = p2; p2 = p1; p1 = mask;
        cmp_due = (k % FRAME == 1);
        if (k % SC == 0) begin
          for (int c = 0; c < 4; c++) begin
            if (samp[((k/SC - 1) % 4)*4 + c]) begin
              hits++;
              hit_code = TB_MAP[((k/SC - 1) % 4)*4 + c];
            end
          end
        end
        if (k % FRAME == 0) begin
          kind = (hits == 0) ? 0 : (hits == 1) ? 1 : 2;
          hits = 0;
          if (kind == 2) begin
            stab = 0;
            prev_kind = 2;
          end else begin
            if (prev_kind == kind && (kind == 0 || prev_code == hit_code))
              stab = (stab + 1 > DEB) ? DEB : stab + 1;
            else
              stab = 1;
            prev_kind = kind;
            prev_code = hit_code;
            if (stab == DEB) begin
              if (kind == 1 && !(exp_pressed && exp_key == hit_code)) begin
                exp_q.push_back(hit_code);
                exp_key = hit_code;
                exp_pressed = 1'b1;
              end else if (kind == 0) begin
                exp_pressed = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and checks state once per frame.
  logic [3:0] want;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (kp_if.valid_o) begin
          nvalid++;
          last_valid_k = k;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got key_o=%h at cycle %0d, required no strobe", kp_if.key_o, k);
          end else begin
            want = exp_q.pop_front();
            if (kp_if.key_o !== want || (k % FRAME) != 1) begin
              errors++;
              $display("FAIL strobe: got key_o=%h at frame phase %0d, required %h at phase 1", kp_if.key_o, k % FRAME, want);
            end else begin
              $display("strobe key=%h cycle=%0d", kp_if.key_o, k);
            end
          end
        end
        if (cmp_due) begin
          checks++;
          if (kp_if.pressed_o !== exp_pressed || kp_if.key_o !== exp_key) begin
            errors++;
            $display("FAIL frame_state: got pressed=%b key=%h, required pressed=%b key=%h (cycle %0d)",
                     kp_if.pressed_o, kp_if.key_o, exp_pressed, exp_key, k);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_row"}, int'(kp_if.row_o), 4'b1110);
    check_val({name, "_key"}, int'(kp_if.key_o), 0);
    check_val({name, "_valid"}, int'(kp_if.valid_o), 0);
    check_val({name, "_pressed"}, int'(kp_if.pressed_o), 0);
  endtask

  int base;
  int idx_a, idx_b, sel, hold;

  initial begin
    // Reset held with '5' (r1,c1) pressed.
    rst  = 1'b1;
    mask = 16'd1 << 5;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    base = nvalid;
    frames(4);
    check_val("rst_accept_count", nvalid - base, 1);
    check_val("rst_accept_late", int'(last_valid_k >= 2*FRAME), 1);
    check_val("rst_accept_key", int'(kp_if.key_o), 5);
    mask = '0;
    frames(3);

    // Press '8' (r2,c1) for 6 frames, then release.
    base = nvalid;
    mask = 16'd1 << 9;
    frames(6);
    check_val("press8_count", nvalid - base, 1);
    check_val("press8_key", int'(kp_if.key_o), 8);
    check_val("press8_pressed", int'(kp_if.pressed_o), 1);
    mask = '0;
    frames(3);
    check_val("release8_pressed", int'(kp_if.pressed_o), 0);
    check_val("release8_key", int'(kp_if.key_o), 8);

    // Bounce '3' every 5 cycles for 3 frames, then hold.
    base = nvalid;
    mask = 16'd1 << 2;
    for (int i = 0; i < 9; i++) begin
      repeat (5) @(negedge clk);
      mask = mask ^ (16'd1 << 2);
    end
    repeat (3) @(negedge clk);
    check_val("bounce_count", nvalid - base, 0);
    mask = 16'd1 << 2;
    frames(3);
    check_val("bounce_hold_count", nvalid - base, 1);
    check_val("bounce_hold_key", int'(kp_if.key_o), 4'h3);
    mask = '0;
    frames(3);

    // Hold 'A', then roll straight over to 'D'.
    base = nvalid;
    mask = 16'd1 << 3;
    frames(4);
    mask = 16'd1 << 15;
    frames(4);
    check_val("rollover_count", nvalid - base, 2);
    check_val("rollover_key", int'(kp_if.key_o), 4'hD);
    check_val("rollover_pressed", int'(kp_if.pressed_o), 1);
    mask = '0;
    frames(3);

    // Chord '1'+'2', then release '2'.
    base = nvalid;
    mask = (16'd1 << 0) | (16'd1 << 1);
    frames(4);
    check_val("chord_count", nvalid - base, 0);
    check_val("chord_key", int'(kp_if.key_o), 4'hD);
    check_val("chord_pressed", int'(kp_if.pressed_o), 0);
    mask = 16'd1 << 0;
    frames(4);
    check_val("chord_release_count", nvalid - base, 1);
    check_val("chord_release_key", int'(kp_if.key_o), 4'h1);
    mask = '0;
    frames(3);

    // Reset mid-frame while 'F' (r3,c2) is held.
    mask = 16'd1 << 14;
    frames(4);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = nvalid;
    frames(4);
    check_val("midreset_accept_count", nvalid - base, 1);
    check_val("midreset_accept_key", int'(kp_if.key_o), 4'hF);
    mask = '0;
    frames(3);

    // Randomized key activity, unaligned with frames.
    for (int i = 0; i < 30; i++) begin
      sel   = $urandom_range(0, 9);
      idx_a = $urandom_range(0, 15);
      idx_b = (idx_a + $urandom_range(1, 15)) % 16;
      if (sel < 3)      mask = '0;
      else if (sel < 9) mask = 16'd1 << idx_a;
      else              mask = (16'd1 << idx_a) | (16'd1 << idx_b);
      hold = $urandom_range(8, 100);
      repeat (hold) @(negedge clk);
    end
    mask = '0;
    frames(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes: %0d strobes still expected, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
